wb_port_arbiter: RTL and testbench

Shares the single register-file write port at the end of the writeback stage between the in-order pipeline writeback and a long-latency auxiliary unit, such as a multi-cycle multiply/divide. The pipeline always wins when it actually writes. Auxiliary results wait in a small FIFO and drain into free slots. A starvation counter can force a one-cycle pipeline hold so that pending auxiliary results always retire. Pending auxiliary entries whose destination is overwritten by a newer pipeline write are squashed to preserve write-after-write order.

---
 rtl/wb_port_arbiter.sv | 178 +++++++++++++++++
 tb/tb_wb_port_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - register-file write port arbiter, pipeline vs auxiliary FIFO; optional starvation hold via WB_ARB_STARVE_EN
module wb_port_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   pipe_we,
    input  logic [4:0]             pipe_dest,
    input  logic [31:0]            pipe_data,
    output logic                   pipe_ack,
    input  logic                   aux_valid,
    output logic                   aux_ready,
    input  logic [4:0]             aux_dest,
    input  logic [31:0]            aux_data,
    output logic                   rf_we,
    output logic [4:0]             rf_dest,
    output logic [31:0]            rf_data,
    output logic                   stall_req,
    output logic [$clog2(DEPTH):0] fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C  = CW'(1);
    localparam logic [AW-1:0] ONE_P  = AW'(1);

    logic [4:0]       dest_q [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [DEPTH-1:0] live_q, live_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    logic empty, full, head_live, head_killed;
    logic pipe_real, pipe_gnt, aux_gnt;
    logic push, store, pop;
    logic stall_q;

    assign empty       = (count_q == '0);
    assign full        = (count_q == FULL_C);
    assign head_live   = !empty && live_q[rd_ptr_q];
    assign head_killed = !empty && !live_q[rd_ptr_q];
    assign pipe_real   = pipe_we && (pipe_dest != 5'd0);

    assign aux_ready  = !full && !reset;
    assign push       = aux_valid && aux_ready;
    // Writes to $0 are handshaken but never occupy a slot.
    assign store      = push && (aux_dest != 5'd0);
    // A killed head leaves without using the port, alongside any pipeline write.
    assign pop        = aux_gnt || head_killed;
    assign fifo_count = count_q;

    // Grant selection and register-file write mux; held stall gives the aux head the port.
    always_comb begin
        aux_gnt  = 1'b0;
        pipe_gnt = 1'b0;
        pipe_ack = 1'b1;
        rf_we    = 1'b0;
        rf_dest  = '0;
        rf_data  = '0;
        if (!reset) begin
            if (stall_q && head_live) begin
                aux_gnt  = 1'b1;
                pipe_ack = 1'b0;
            end else if (pipe_real) begin
                pipe_gnt = 1'b1;
            end else if (head_live) begin
                aux_gnt = 1'b1;
            end
        end
        if (pipe_gnt) begin
            rf_we   = 1'b1;
            rf_dest = pipe_dest;
            rf_data = pipe_data;
        end else if (aux_gnt) begin
            rf_we   = 1'b1;
            rf_dest = dest_q[rd_ptr_q];
            rf_data = data_q[rd_ptr_q];
        end
    end

    // Pointer/count update plus live bits; squash precedes the same-cycle enqueue so the new entry survives.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        live_d   = live_q;
        if (pop) begin
            rd_ptr_d         = rd_ptr_q + ONE_P;
            live_d[rd_ptr_q] = 1'b0;
        end
        if (pipe_gnt) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (dest_q[i] == pipe_dest) begin
                    live_d[i] = 1'b0;
                end
            end
        end
        if (store) begin
            wr_ptr_d         = wr_ptr_q + ONE_P;
            live_d[wr_ptr_q] = 1'b1;
        end
        if (store && !pop) begin
            count_d = count_q + ONE_C;
        end else if (!store && pop) begin
            count_d = count_q - ONE_C;
        end
    end

    // FIFO control state with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            live_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            live_q   <= live_d;
        end
    end

    // Payload storage; contents are only meaningful where live bits and count say so.
    always_ff @(posedge clk) begin
        if (store) begin
            dest_q[wr_ptr_q] <= aux_dest;
            data_q[wr_ptr_q] <= aux_data;
        end
    end

`ifdef WB_ARB_STARVE_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);
    localparam logic [SW-1:0] ONE_S   = SW'(1);

    logic [SW-1:0] starve_q, starve_d;
    logic          stall_d;

    // Count cycles a live head is passed over; any aux grant or an empty FIFO restarts it.
    always_comb begin
        starve_d = starve_q;
        stall_d  = stall_q;
        if (aux_gnt || empty) begin
            starve_d = '0;
        end else if (head_live && (starve_q != LIMIT_C)) begin
            starve_d = starve_q + ONE_S;
        end
        if (aux_gnt) begin
            stall_d = 1'b0;
        end else if (stall_q && !head_live) begin
            stall_d = 1'b0;
        end else if (starve_d == LIMIT_C) begin
            stall_d = 1'b1;
        end
    end

    // Starvation counter and registered hold request.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_q <= '0;
            stall_q  <= 1'b0;
        end else begin
            starve_q <= starve_d;
            stall_q  <= stall_d;
        end
    end

    assign stall_req = stall_q;
`else
    assign stall_q   = 1'b0;
    assign stall_req = 1'b0;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - directed self-checking bench for wb_port_arbiter
module tb_wb_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        pipe_we;
    logic [4:0]  pipe_dest;
    logic [31:0] pipe_data;
    logic        pipe_ack;
    logic        aux_valid;
    logic        aux_ready;
    logic [4:0]  aux_dest;
    logic [31:0] aux_data;
    logic        rf_we;
    logic [4:0]  rf_dest;
    logic [31:0] rf_data;
    logic        stall_req;
    logic [2:0]  fifo_count;

    int n_cmp = 0;
    int n_bad = 0;

    wb_port_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
        .clk(clk), .reset(reset),
        .pipe_we(pipe_we), .pipe_dest(pipe_dest), .pipe_data(pipe_data), .pipe_ack(pipe_ack),
        .aux_valid(aux_valid), .aux_ready(aux_ready), .aux_dest(aux_dest), .aux_data(aux_data),
        .rf_we(rf_we), .rf_dest(rf_dest), .rf_data(rf_data),
        .stall_req(stall_req), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; pipe_we = 1'b1; pipe_dest = 5'd3; pipe_data = 32'hDEAD;
        aux_valid = 1'b1; aux_dest = 5'd4; aux_data = 32'h4444;
        step(); #2;
        n_cmp++;
        if (rf_we !== 1'b0 || rf_dest !== 5'd0 || rf_data !== 32'd0) begin
            n_bad++; $display("FAIL reset_rf: got we=%0b dest=%0d data=%h want 0/0/0", rf_we, rf_dest, rf_data);
        end
        n_cmp++;
        if (aux_ready !== 1'b0 || pipe_ack !== 1'b1 || stall_req !== 1'b0 || fifo_count !== 3'd0) begin
            n_bad++; $display("FAIL reset_ctl: got ready=%0b ack=%0b stall=%0b count=%0d want 0/1/0/0", aux_ready, pipe_ack, stall_req, fifo_count);
        end
        step();
        reset = 1'b0; pipe_we = 1'b0; aux_valid = 1'b0; #2;
        n_cmp++;
        if (fifo_count !== 3'd0 || rf_we !== 1'b0) begin
            n_bad++; $display("FAIL reset_release: got count=%0d we=%0b want 0/0", fifo_count, rf_we);
        end
    endtask

    task automatic test_free_slot_drain();
        aux_valid = 1'b1; aux_dest = 5'd5; aux_data = 32'h1234; #2;
        n_cmp++;
        if (aux_ready !== 1'b1 || rf_we !== 1'b0) begin
            n_bad++; $display("FAIL drain_enq: got ready=%0b we=%0b want 1/0", aux_ready, rf_we);
        end
        step();
        aux_valid = 1'b0; #2;
        n_cmp++;
        if (rf_we !== 1'b1 || rf_dest !== 5'd5 || rf_data !== 32'h1234 || fifo_count !== 3'd1) begin
            n_bad++; $display("FAIL drain_out: got we=%0b dest=%0d data=%h count=%0d want 1/5/1234/1", rf_we, rf_dest, rf_data, fifo_count);
        end
        step(); #2;
        n_cmp++;
        if (fifo_count !== 3'd0 || rf_we !== 1'b0) begin
            n_bad++; $display("FAIL drain_empty: got count=%0d we=%0b want 0/0", fifo_count, rf_we);
        end
        // Aux to $0 is accepted but dropped; pipeline to $0 is no write.
        aux_valid = 1'b1; aux_dest = 5'd0; aux_data = 32'hFFFF;
        pipe_we = 1'b1; pipe_dest = 5'd0; pipe_data = 32'h5555; #2;
        n_cmp++;
        if (aux_ready !== 1'b1 || rf_we !== 1'b0 || pipe_ack !== 1'b1) begin
            n_bad++; $display("FAIL zero_dest: got ready=%0b we=%0b ack=%0b want 1/0/1", aux_ready, rf_we, pipe_ack);
        end
        step();
        aux_valid = 1'b0; pipe_we = 1'b0; #2;
        n_cmp++;
        if (fifo_count !== 3'd0 || rf_we !== 1'b0) begin
            n_bad++; $display("FAIL zero_dest_drop: got count=%0d we=%0b want 0/0", fifo_count, rf_we);
        end
    endtask

    task automatic test_priority();
        pipe_we = 1'b1; pipe_dest = 5'd3; pipe_data = 32'hAAAA;
        aux_valid = 1'b1; aux_dest = 5'd7; aux_data = 32'h7777; #2;
        n_cmp++;
        if (rf_we !== 1'b1 || rf_dest !== 5'd3 || rf_data !== 32'hAAAA) begin
            n_bad++; $display("FAIL prio_first: got we=%0b dest=%0d data=%h want 1/3/aaaa", rf_we, rf_dest, rf_data);
        end
        step();
        aux_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #2;
            n_cmp++;
            if (rf_dest !== 5'd3 || rf_data !== 32'hAAAA || fifo_count !== 3'd1 || pipe_ack !== 1'b1 || stall_req !== 1'b0) begin
                n_bad++; $display("FAIL prio_hold[%0d]: got dest=%0d data=%h count=%0d ack=%0b stall=%0b want 3/aaaa/1/1/0", c, rf_dest, rf_data, fifo_count, pipe_ack, stall_req);
            end
            step();
        end
        pipe_dest = 5'd0; #2;
        n_cmp++;
        if (rf_we !== 1'b1 || rf_dest !== 5'd7 || rf_data !== 32'h7777) begin
            n_bad++; $display("FAIL prio_slot: got we=%0b dest=%0d data=%h want 1/7/7777", rf_we, rf_dest, rf_data);
        end
        step();
        pipe_we = 1'b0; #2;
        n_cmp++;
        if (fifo_count !== 3'd0 || rf_we !== 1'b0) begin
            n_bad++; $display("FAIL prio_done: got count=%0d we=%0b want 0/0", fifo_count, rf_we);
        end
    endtask

    task automatic test_starvation();
        pipe_we = 1'b1; pipe_dest = 5'd3; pipe_data = 32'hAAAA;
        aux_valid = 1'b1; aux_dest = 5'd7; aux_data = 32'h7777;
        step();
        aux_valid = 1'b0;
`ifdef WB_ARB_STARVE_EN
        for (int c = 1; c <= 8; c++) begin
            #2;
            n_cmp++;
            if (stall_req !== 1'b0 || rf_dest !== 5'd3 || pipe_ack !== 1'b1) begin
                n_bad++; $display("FAIL starve_wait[%0d]: got stall=%0b dest=%0d ack=%0b want 0/3/1", c, stall_req, rf_dest, pipe_ack);
            end
            step();
        end
        #2;
        n_cmp++;
        if (stall_req !== 1'b1 || rf_dest !== 5'd7 || rf_data !== 32'h7777 || pipe_ack !== 1'b0) begin
            n_bad++; $display("FAIL starve_hold: got stall=%0b dest=%0d data=%h ack=%0b want 1/7/7777/0", stall_req, rf_dest, rf_data, pipe_ack);
        end
        step(); #2;
        n_cmp++;
        if (stall_req !== 1'b0 || rf_dest !== 5'd3 || pipe_ack !== 1'b1 || fifo_count !== 3'd0) begin
            n_bad++; $display("FAIL starve_after: got stall=%0b dest=%0d ack=%0b count=%0d want 0/3/1/0", stall_req, rf_dest, pipe_ack, fifo_count);
        end
`else
        for (int c = 1; c <= 12; c++) begin
            #2;
            n_cmp++;
            if (stall_req !== 1'b0 || rf_dest !== 5'd3 || pipe_ack !== 1'b1 || fifo_count !== 3'd1) begin
                n_bad++; $display("FAIL nostarve[%0d]: got stall=%0b dest=%0d ack=%0b count=%0d want 0/3/1/1", c, stall_req, rf_dest, pipe_ack, fifo_count);
            end
            step();
        end
        pipe_we = 1'b0; #2;
        n_cmp++;
        if (rf_we !== 1'b1 || rf_dest !== 5'd7) begin
            n_bad++; $display("FAIL nostarve_slot: got we=%0b dest=%0d want 1/7", rf_we, rf_dest);
        end
        step();
`endif
        pipe_we = 1'b0;
        step();
    endtask

    task automatic test_squash();
        pipe_we = 1'b0; aux_valid = 1'b1; aux_dest = 5'd9; aux_data = 32'h9999;
        step();
        aux_valid = 1'b0; pipe_we = 1'b1; pipe_dest = 5'd9; pipe_data = 32'hBEEF; #2;
        n_cmp++;
        if (rf_we !== 1'b1 || rf_dest !== 5'd9 || rf_data !== 32'hBEEF || fifo_count !== 3'd1) begin
            n_bad++; $display("FAIL squash_pipe: got we=%0b dest=%0d data=%h count=%0d want 1/9/beef/1", rf_we, rf_dest, rf_data, fifo_count);
        end
        step();
        pipe_we = 1'b0; #2;
        n_cmp++;
        if (rf_we !== 1'b0 || fifo_count !== 3'd1) begin
            n_bad++; $display("FAIL squash_pop: got we=%0b dest=%0d data=%h count=%0d want 0/x/x/1", rf_we, rf_dest, rf_data, fifo_count);
        end
        step(); #2;
        n_cmp++;
        if (rf_we !== 1'b0 || fifo_count !== 3'd0) begin
            n_bad++; $display("FAIL squash_gone: got we=%0b count=%0d want 0/0", rf_we, fifo_count);
        end
    endtask

    task automatic test_full_wrap();
        pipe_we = 1'b1; pipe_dest = 5'd3; pipe_data = 32'hAAAA;
        for (int i = 0; i < 4; i++) begin
            aux_valid = 1'b1; aux_dest = 5'(10 + i); aux_data = 32'hA000_0000 + 32'(i); #2;
            n_cmp++;
            if (aux_ready !== 1'b1 || fifo_count !== 3'(i)) begin
                n_bad++; $display("FAIL fill[%0d]: got ready=%0b count=%0d want 1/%0d", i, aux_ready, fifo_count, i);
            end
            step();
        end
        aux_valid = 1'b0; #2;
        n_cmp++;
        if (aux_ready !== 1'b0 || fifo_count !== 3'd4) begin
            n_bad++; $display("FAIL full: got ready=%0b count=%0d want 0/4", aux_ready, fifo_count);
        end
        step();
        pipe_we = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k + 3 < 8 && k >= 1) begin
                aux_valid = 1'b1; aux_dest = 5'(10 + k + 3); aux_data = 32'hA000_0000 + 32'(k + 3);
            end else if (k == 0) begin
                aux_valid = 1'b1; aux_dest = 5'd14; aux_data = 32'hA000_0004;
            end else begin
                aux_valid = 1'b0;
            end
            #2;
            n_cmp++;
            if (rf_we !== 1'b1 || rf_dest !== 5'(10 + k) || rf_data !== 32'hA000_0000 + 32'(k)) begin
                n_bad++; $display("FAIL wrap_out[%0d]: got we=%0b dest=%0d data=%h want 1/%0d/%h", k, rf_we, rf_dest, rf_data, 10 + k, 32'hA000_0000 + 32'(k));
            end
            n_cmp++;
            if (fifo_count !== ((k == 0) ? 3'd4 : (k <= 5) ? 3'd3 : 3'(8 - k)) || aux_ready !== (k != 0)) begin
                n_bad++; $display("FAIL wrap_cnt[%0d]: got count=%0d ready=%0b want %0d/%0b", k, fifo_count, aux_ready, (k == 0) ? 4 : (k <= 5) ? 3 : 8 - k, k != 0);
            end
            step();
        end
        aux_valid = 1'b0; #2;
        n_cmp++;
        if (fifo_count !== 3'd0 || rf_we !== 1'b0) begin
            n_bad++; $display("FAIL wrap_empty: got count=%0d we=%0b want 0/0", fifo_count, rf_we);
        end
    endtask

    task automatic test_reset_mid_stall();
        int waited;
        pipe_we = 1'b1; pipe_dest = 5'd3; pipe_data = 32'hAAAA;
        for (int i = 0; i < 3; i++) begin
            aux_valid = 1'b1; aux_dest = 5'(20 + i); aux_data = 32'hC000_0000 + 32'(i);
            step();
        end
        aux_valid = 1'b0;
`ifdef WB_ARB_STARVE_EN
        waited = 0;
        #2;
        while (stall_req !== 1'b1 && waited < 20) begin
            step(); #2;
            waited++;
        end
        n_cmp++;
        if (stall_req !== 1'b1) begin
            n_bad++; $display("FAIL rst_stall_reach: got stall=%0b after %0d cycles want 1", stall_req, waited);
        end
`else
        waited = 0;
        #2;
`endif
        n_cmp++;
        if (fifo_count !== 3'd3) begin
            n_bad++; $display("FAIL rst_pre_count: got count=%0d want 3 (waited %0d)", fifo_count, waited);
        end
        step();
        reset = 1'b1; #2;
        n_cmp++;
        if (rf_we !== 1'b0 || aux_ready !== 1'b0 || pipe_ack !== 1'b1) begin
            n_bad++; $display("FAIL rst_during: got we=%0b ready=%0b ack=%0b want 0/0/1", rf_we, aux_ready, pipe_ack);
        end
        step();
        reset = 1'b0; pipe_we = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #2;
            n_cmp++;
            if (fifo_count !== 3'd0 || stall_req !== 1'b0 || rf_we !== 1'b0) begin
                n_bad++; $display("FAIL rst_after[%0d]: got count=%0d stall=%0b we=%0b want 0/0/0", c, fifo_count, stall_req, rf_we);
            end
            step();
        end
    endtask

    initial begin
        reset = 1'b1; pipe_we = 1'b0; pipe_dest = '0; pipe_data = '0;
        aux_valid = 1'b0; aux_dest = '0; aux_data = '0;
        test_reset();
        test_free_slot_drain();
        test_priority();
        test_starvation();
        test_squash();
        test_full_wrap();
        test_reset_mid_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
